vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL, 800, pixel ticks per line.
REQ-002 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-003 SHALL have parameter H_SYNC_START, 656, pixel index of hsync falling edge.
REQ-004 SHALL have parameter H_SYNC_W, 96, hsync low width in ticks.
REQ-005 SHALL have parameter V_TOTAL, 525, lines per frame.
REQ-006 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-007 SHALL have parameter V_SYNC_START, 490, line index of vsync falling edge.
REQ-008 SHALL have parameter V_SYNC_W, 2, vsync low width in hsync edges.
REQ-009 SHALL have parameter LOCK_LINES, 2, consecutive good lines before horizontal acquisition completes.
REQ-010 SHALL have port clk, input, 1, sole clock; one clock; reset is synchronous and active-high.
REQ-011 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-012 SHALL have port select, input, 1, pixel tick enable; all state advances only on clk edges with select=1.
REQ-013 SHALL have ports h_sync and v_sync, input, 1 each, active-low syncs from the timing generator.
REQ-014 SHALL have ports hcount and vcount, output, 10 each, recovered pixel and line position.
REQ-015 SHALL have ports video_on, locked, frame_start and sync_err, output, 1 each.
REQ-016 SHALL have port err_cnt, output, 8, saturating count of sync_err pulses.

Function
REQ-017 SHALL register h_sync/v_sync on each tick as hs_d/vs_d; hsync falling edge = (h_sync=0 and hs_d=1) on a tick; rising edge and vsync edges are defined the same way.
REQ-018 SHALL keep h_per (10-bit): loads 1 on hsync falling-edge tick, else increments on each tick, saturating at 1023; period check = h_per equals H_TOTAL at a falling-edge tick.
REQ-019 SHALL keep h_low: counts ticks with h_sync=0; width check = h_low equals H_SYNC_W at a rising-edge tick.
REQ-020 SHALL keep v_per (10-bit): counts hsync falling edges, loads 1 at a vsync falling edge; frame check = v_per equals V_TOTAL at a vsync falling edge; v_low counts hsync falling edges while v_sync=0, and vsync width check = v_low equals V_SYNC_W at vsync rising edge.
REQ-021 SHALL increment hcount on each tick, wrapping H_TOTAL-1 to 0; at an hsync falling-edge tick, hcount loads H_SYNC_START+1.
REQ-022 SHALL increment vcount when hcount wraps, wrapping V_TOTAL-1 to 0; at a vsync falling-edge tick, vcount loads V_SYNC_START (takes priority over a same-tick wrap increment).
REQ-023 SHALL implement FSM SEARCH, H_ACQ, V_ACQ, LOCKED; locked=1 only in LOCKED.
REQ-024 SEARCH: the first hsync falling edge SHALL transition to H_ACQ, with good-line counter cleared.
REQ-025 H_ACQ: each good line (period and width pass) SHALL increment good, a bad line SHALL clear good, and good=LOCK_LINES SHALL transition to V_ACQ.
REQ-026 V_ACQ: an hsync failure SHALL transition to SEARCH; a vsync falling edge with a passing frame check and the preceding width check SHALL transition to LOCKED; otherwise v_per SHALL restart and the FSM SHALL remain in V_ACQ.
REQ-027 LOCKED: any failed h/v period or width check, or h_per reaching 1023 (missing sync), SHALL pulse sync_err for one clk, increment err_cnt (saturating at 255), and transition to SEARCH.
REQ-028 SHALL drive video_on = locked and hcount<H_ACTIVE and vcount<V_ACTIVE, registered, same cycle as the hcount/vcount it describes.
REQ-029 SHALL pulse frame_start for one clk on the tick where hcount and vcount both become 0 while locked.
REQ-030 With select=0, SHALL hold all registers and keep pulses low.

Reset
REQ-031 rst SHALL force SEARCH, hcount=vcount=0, h_per=v_per=h_low=v_low=0, hs_d=vs_d=1, video_on=locked=frame_start=sync_err=0, err_cnt=0; it takes precedence over select and applies mid-frame.

Structure
REQ-032 SHALL place timing defaults and the FSM state encoding in shared package vga_timing_pkg, also used by the generator.
REQ-033 SHALL use one sub-module sync_edge_meter, instantiated twice (h and v), providing edge detection, period and low-width counters and pass flags.

Verification
REQ-034 Generator-driven 640x480, select every clk: SHALL reach locked within 2 frames, after which decoder hcount/vcount track the generator with fixed offset 0 and video_on matches.
REQ-035 Once locked, stretch one line to 801 ticks: SHALL pulse sync_err once, err_cnt=1, state SEARCH, and re-lock within 2 frames.
REQ-036 Hold h_sync high 1100 ticks while locked: SHALL raise sync_err at h_per=1023 and drop locked.
REQ-037 Send vsync low for 3 lines in V_ACQ: SHALL NOT lock that frame, and SHALL lock on the next correct frame.
REQ-038 Assert rst at vcount=200 while locked: next cycle all outputs SHALL be at reset values, and err_cnt SHALL be unchanged by the reset path except cleared to 0.
REQ-039 Toggle select 1-in-4: SHALL reach the same lock, hcount SHALL advance only on select cycles, and frame_start SHALL be one clk wide.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and decoder state encoding.
// Used by the sync decoder and by the timing generator.
package vga_timing_pkg;

   localparam int H_TOTAL_DEF      = 800;
   localparam int H_ACTIVE_DEF     = 640;
   localparam int H_SYNC_START_DEF = 656;
   localparam int H_SYNC_W_DEF     = 96;
   localparam int V_TOTAL_DEF      = 525;
   localparam int V_ACTIVE_DEF     = 480;
   localparam int V_SYNC_START_DEF = 490;
   localparam int V_SYNC_W_DEF     = 2;
   localparam int LOCK_LINES_DEF   = 2;

   // Period/width counters saturate here; reaching it means the sync has gone missing.
   localparam logic [9:0] CNT_MAX = 10'h3FF;
   localparam logic [7:0] ERR_MAX = 8'hFF;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      H_ACQ  = 2'd1,
      V_ACQ  = 2'd2,
      LOCKED = 2'd3
   } sync_state_t;

endpackage

// File: rtl/sync_edge_meter.sv
// Edge detector plus period and low-width meter for one active-low sync line.
// The period counter restarts at 1 on each falling edge; the low counter counts
// enabled events while the sync is low and is checked on the rising edge.
module sync_edge_meter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL  = 800,
   parameter int SYNC_W = 96
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic count_en,
   input  logic sync,
   output logic fall,
   output logic rise,
   output logic per_pass,
   output logic per_sat,
   output logic width_pass,
   output logic width_good
);

   localparam logic [9:0] TOTAL_C  = 10'(TOTAL);
   localparam logic [9:0] SYNC_W_C = 10'(SYNC_W);

   logic       sync_d;
   logic [9:0] per;
   logic [9:0] low;

   assign fall       = tick & ~sync & sync_d;
   assign rise       = tick & sync & ~sync_d;
   assign per_pass   = (per == TOTAL_C);
   assign per_sat    = (per == CNT_MAX);
   assign width_pass = (low == SYNC_W_C);

   // Sample the sync, run the period/low counters and latch the last width verdict.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_d     <= 1'b1;
         per        <= '0;
         low        <= '0;
         width_good <= 1'b0;
      end else if (tick) begin
         sync_d <= sync;
         if (fall) begin
            per <= 10'd1;
            low <= count_en ? 10'd1 : 10'd0;
         end else begin
            if (count_en && per != CNT_MAX) per <= per + 10'd1;
            if (count_en && !sync && low != CNT_MAX) low <= low + 10'd1;
         end
         if (rise) width_good <= width_pass;
      end
   end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from incoming active-low VGA syncs, acquires
// horizontal then vertical lock, and flags/counts sync errors once locked.
module vga_sync_decoder
   import vga_timing_pkg::*;
#(
   parameter int H_TOTAL      = H_TOTAL_DEF,
   parameter int H_ACTIVE     = H_ACTIVE_DEF,
   parameter int H_SYNC_START = H_SYNC_START_DEF,
   parameter int H_SYNC_W     = H_SYNC_W_DEF,
   parameter int V_TOTAL      = V_TOTAL_DEF,
   parameter int V_ACTIVE     = V_ACTIVE_DEF,
   parameter int V_SYNC_START = V_SYNC_START_DEF,
   parameter int V_SYNC_W     = V_SYNC_W_DEF,
   parameter int LOCK_LINES   = LOCK_LINES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       select,
   input  logic       h_sync,
   input  logic       v_sync,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       video_on,
   output logic       locked,
   output logic       frame_start,
   output logic       sync_err,
   output logic [7:0] err_cnt
);

   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_LOAD    = 10'(H_SYNC_START + 1);
   localparam logic [9:0] V_LOAD    = 10'(V_SYNC_START);
   localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
   localparam logic [7:0] GOOD_LAST = 8'(LOCK_LINES - 1);

   logic h_fall, h_rise, h_per_pass, h_per_sat, h_w_pass, h_w_good;
   logic v_fall, v_rise, v_per_pass, v_per_sat, v_w_pass, v_w_good;
   logic h_fail, v_fail, h_wrap, err_evt;
   logic [9:0] hc_nxt, vc_nxt;
   logic [7:0] good, good_nxt;
   sync_state_t state, state_nxt;

   // Horizontal meter: counts pixel ticks.
   sync_edge_meter #(.TOTAL(H_TOTAL), .SYNC_W(H_SYNC_W)) u_h_meter (
      .clk(clk), .rst(rst), .tick(select), .count_en(select), .sync(h_sync),
      .fall(h_fall), .rise(h_rise), .per_pass(h_per_pass), .per_sat(h_per_sat),
      .width_pass(h_w_pass), .width_good(h_w_good)
   );

   // Vertical meter: counts hsync falling edges (lines).
   sync_edge_meter #(.TOTAL(V_TOTAL), .SYNC_W(V_SYNC_W)) u_v_meter (
      .clk(clk), .rst(rst), .tick(select), .count_en(h_fall), .sync(v_sync),
      .fall(v_fall), .rise(v_rise), .per_pass(v_per_pass), .per_sat(v_per_sat),
      .width_pass(v_w_pass), .width_good(v_w_good)
   );

   assign h_fail = (h_fall && !h_per_pass) || (h_rise && !h_w_pass) || (select && h_per_sat);
   assign v_fail = (v_fall && !v_per_pass) || (v_rise && !v_w_pass) || (select && v_per_sat);
   assign h_wrap = !h_fall && (hcount == H_LAST);
   assign locked = (state == LOCKED);

   // Next pixel/line position; sync edges re-anchor the free-running counters.
   always_comb begin
      hc_nxt = hcount;
      vc_nxt = vcount;
      if (select) begin
         if (h_fall)      hc_nxt = H_LOAD;
         else if (h_wrap) hc_nxt = '0;
         else             hc_nxt = hcount + 10'd1;
         if (v_fall)      vc_nxt = V_LOAD;
         else if (h_wrap) vc_nxt = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end
   end

   // Acquisition FSM: horizontal qualification, then a clean frame, then lock.
   always_comb begin
      state_nxt = state;
      good_nxt  = good;
      err_evt   = 1'b0;
      if (select) begin
         case (state)
            SEARCH: if (h_fall) begin
               state_nxt = H_ACQ;
               good_nxt  = '0;
            end
            H_ACQ: if (h_fall) begin
               if (h_per_pass && h_w_good) begin
                  good_nxt = good + 8'd1;
                  if (good == GOOD_LAST) state_nxt = V_ACQ;
               end else begin
                  good_nxt = '0;
               end
            end
            V_ACQ: begin
               if (h_fail)                                  state_nxt = SEARCH;
               else if (v_fall && v_per_pass && v_w_good)   state_nxt = LOCKED;
            end
            LOCKED: if (h_fail || v_fail) begin
               state_nxt = SEARCH;
               err_evt   = 1'b1;
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   // State, position and flag registers; flags describe the position registered alongside them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SEARCH;
         good        <= '0;
         hcount      <= '0;
         vcount      <= '0;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
         err_cnt     <= '0;
      end else begin
         state       <= state_nxt;
         good        <= good_nxt;
         hcount      <= hc_nxt;
         vcount      <= vc_nxt;
         video_on    <= (state_nxt == LOCKED) && (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
         frame_start <= select && (state_nxt == LOCKED) && (hc_nxt == '0) && (vc_nxt == '0);
         sync_err    <= err_evt;
         if (err_evt && err_cnt != ERR_MAX) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a reduced-size timing generator drives the
// decoder; expected positions/flags are queued per tick and compared after it.
module tb_vga_sync_decoder;
   import vga_timing_pkg::*;

   localparam int HT = 40, HA = 32, HSS = 33, HSW = 4;
   localparam int VT = 20, VA = 15, VSS = 16, VSW = 2;
   localparam int FRAME = HT * VT;

   logic       clk = 1'b0;
   logic       rst, select, h_sync, v_sync;
   logic [9:0] hcount, vcount;
   logic       video_on, locked, frame_start, sync_err;
   logic [7:0] err_cnt;

   vga_sync_decoder #(
      .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
      .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_W(VSW),
      .LOCK_LINES(2)
   ) dut (
      .clk(clk), .rst(rst), .select(select), .h_sync(h_sync), .v_sync(v_sync),
      .hcount(hcount), .vcount(vcount), .video_on(video_on), .locked(locked),
      .frame_start(frame_start), .sync_err(sync_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] hc;
      logic [9:0] vc;
      logic       von;
      logic       fs;
      logic       lk;
      logic       se;
   } exp_t;

   exp_t   sb_q[$];
   int     n_cmp = 0, n_bad = 0;
   int     g_hc = 0, g_vc = 0, g_vsw = VSW;
   bit     hold_hs = 1'b0, stretch = 1'b0;
   int     sel_div = 1;
   int     cyc = 0, tn = 0, last_fall_tn = 0, err_tn = 0;
   logic   prev_hs = 1'b1;
   int     n_serr = 0, n_fs = 0, n_lk = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic gen_hs(input int hc);
      return !(hc >= HSS && hc < HSS + HSW);
   endfunction

   // vsync is keyed to the hsync falling edge, so its edges coincide with one.
   function automatic logic gen_vs(input int hc, input int vc);
      int ln;
      ln = (hc >= HSS) ? vc : ((vc == 0) ? VT - 1 : vc - 1);
      return !(ln >= VSS && ln < VSS + g_vsw);
   endfunction

   task automatic tick(input bit trk);
      bit   sel;
      int   nhc, nvc;
      exp_t e, o;
      sel    = ((cyc % sel_div) == 0);
      select = sel;
      h_sync = hold_hs ? 1'b1 : gen_hs(g_hc);
      v_sync = hold_hs ? 1'b1 : gen_vs(g_hc, g_vc);
      nhc = g_hc;
      nvc = g_vc;
      if (sel) begin
         tn++;
         if (prev_hs && !h_sync) last_fall_tn = tn;
         prev_hs = h_sync;
         if (stretch && g_hc == HT - 1) stretch = 1'b0;
         else if (g_hc == HT - 1) begin
            nhc = 0;
            nvc = (g_vc == VT - 1) ? 0 : g_vc + 1;
         end else nhc = g_hc + 1;
      end
      if (trk) begin
         e.hc  = 10'(nhc);
         e.vc  = 10'(nvc);
         e.von = (nhc < HA) && (nvc < VA);
         e.fs  = sel && (nhc == 0) && (nvc == 0);
         e.lk  = 1'b1;
         e.se  = 1'b0;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
      g_hc = nhc;
      g_vc = nvc;
      if (sync_err)    begin n_serr++; err_tn = tn; end
      if (frame_start) n_fs++;
      if (locked)      n_lk++;
      if (trk && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         o.hc = hcount; o.vc = vcount; o.von = video_on;
         o.fs = frame_start; o.lk = locked; o.se = sync_err;
         chk("track", 32'(o), 32'(e));
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   task automatic track(input int n);
      for (int i = 0; i < n; i++) tick(1'b1);
   endtask

   task automatic run_to(input int vc, input int hc, input int bound);
      for (int i = 0; i < bound && !(g_vc == vc && g_hc == hc); i++) tick(1'b0);
   endtask

   task automatic wait_lock(input string tag, input int bound);
      for (int i = 0; i < bound && !locked; i++) tick(1'b0);
      chk(tag, 32'(locked), 32'd1);
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_hcount"},   32'(hcount),      32'd0);
      chk({pfx, "_vcount"},   32'(vcount),      32'd0);
      chk({pfx, "_video_on"}, 32'(video_on),    32'd0);
      chk({pfx, "_locked"},   32'(locked),      32'd0);
      chk({pfx, "_fstart"},   32'(frame_start), 32'd0);
      chk({pfx, "_sync_err"}, 32'(sync_err),    32'd0);
      chk({pfx, "_err_cnt"},  32'(err_cnt),     32'd0);
   endtask

   initial begin
      rst = 1'b1; select = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");
      rst = 1'b0;

      // Nominal timing, select every clock.
      wait_lock("lock_initial", 2 * FRAME);
      n_fs = 0;
      track(FRAME);
      chk("fs_per_frame", 32'(n_fs), 32'd1);

      // One line stretched by a tick.
      n_serr  = 0;
      stretch = 1'b1;
      run(2 * HT);
      chk("stretch_err_pulses", 32'(n_serr), 32'd1);
      chk("stretch_err_cnt", 32'(err_cnt), 32'd1);
      chk("stretch_unlocked", 32'(locked), 32'd0);
      wait_lock("relock_stretch", 2 * FRAME);
      track(FRAME / 2);

      // Both syncs stuck high.
      run_to(2, 0, 2 * FRAME);
      n_serr  = 0;
      hold_hs = 1'b1;
      run(1100);
      hold_hs = 1'b0;
      chk("stuck_err_pulses", 32'(n_serr), 32'd1);
      chk("stuck_err_at_sat", 32'(err_tn - last_fall_tn), 32'(CNT_MAX));
      chk("stuck_unlocked", 32'(locked), 32'd0);
      chk("stuck_err_cnt", 32'(err_cnt), 32'd2);
      wait_lock("relock_stuck", 3 * FRAME);
      track(FRAME / 2);

      // Reset mid-frame while locked.
      run_to(8, 5, 2 * FRAME);
      chk("pre_rst_locked", 32'(locked), 32'd1);
      chk("pre_rst_err_cnt", 32'(err_cnt), 32'd2);
      rst = 1'b1;
      tick(1'b0);
      rst = 1'b0;
      chk_reset("midrst");

      // Over-wide vsync while acquiring vertically.
      g_vsw = 3;
      n_lk  = 0;
      run_to(0, 0, 2 * FRAME);
      g_vsw = VSW;
      run_to(17, 0, 2 * FRAME);
      chk("no_lock_after_wide", 32'(n_lk), 32'd0);
      wait_lock("lock_after_wide", FRAME);
      track(FRAME / 2);

      // select asserted one clock in four.
      sel_div = 4;
      rst = 1'b1;
      tick(1'b0);
      rst = 1'b0;
      wait_lock("lock_sel4", 3 * FRAME * 4);
      n_fs = 0;
      track(FRAME * 4);
      chk("fs_sel4", 32'(n_fs), 32'd1);
      chk("sel4_err_cnt", 32'(err_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
